// File: rtl/rggen_register_access_sequencer.sv
// Host-to-register access sequencer: replays one host request on the register bus and
// returns status/read data, with decode-miss, timeout and illegal-access error generation.
module rggen_register_access_sequencer #(
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_host_valid,
  output logic                     o_host_ready,
  input  logic [1:0]               i_host_access,
  input  logic [ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [DATA_WIDTH-1:0]    i_host_write_data,
  input  logic [DATA_WIDTH-1:0]    i_host_strobe,
  output logic                     o_host_response_valid,
  input  logic                     i_host_response_ready,
  output logic [1:0]               o_host_status,
  output logic [DATA_WIDTH-1:0]    o_host_read_data,
  output logic                     o_posted_error,
  output logic                     o_reg_valid,
  output logic [1:0]               o_reg_access,
  output logic [ADDRESS_WIDTH-1:0] o_reg_address,
  output logic [DATA_WIDTH-1:0]    o_reg_write_data,
  output logic [DATA_WIDTH-1:0]    o_reg_strobe,
  input  logic                     i_reg_hit,
  input  logic                     i_reg_ready,
  input  logic [1:0]               i_reg_status,
  input  logic [DATA_WIDTH-1:0]    i_reg_read_data
);

  localparam logic [1:0] AccessIllegal     = 2'b00;
  localparam logic [1:0] AccessPostedWrite = 2'b01;
  localparam logic [1:0] AccessRead        = 2'b10;

  localparam logic [1:0] StatusSlaveError  = 2'b10;
  localparam logic [1:0] StatusDecodeError = 2'b11;

  localparam int unsigned CountWidth =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CountWidth-1:0] CountLast =
    (TIMEOUT_CYCLES > 0) ? CountWidth'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResponse
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic [DATA_WIDTH-1:0]    strobe_q, strobe_d;
  logic [1:0]               status_q, status_d;
  logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
  logic [CountWidth-1:0]    count_q, count_d;
  logic                     posted_error_q, posted_error_d;

  logic                     done;
  logic [1:0]               done_status;
  logic [DATA_WIDTH-1:0]    done_data;

  always_comb begin
    state_d        = state_q;
    access_d       = access_q;
    address_d      = address_q;
    write_data_d   = write_data_q;
    strobe_d       = strobe_q;
    status_d       = status_q;
    read_data_d    = read_data_q;
    count_d        = count_q;
    posted_error_d = 1'b0;
    done           = 1'b0;
    done_status    = 2'b00;
    done_data      = '0;

    unique case (state_q)
      StIdle: begin
        if (i_host_valid) begin
          access_d     = i_host_access;
          address_d    = i_host_address;
          write_data_d = i_host_write_data;
          strobe_d     = i_host_strobe;
          if (i_host_access == AccessIllegal) begin
            status_d    = StatusSlaveError;
            read_data_d = '0;
            state_d     = StResponse;
          end else begin
            count_d = '0;
            state_d = StAccess;
          end
        end
      end

      StAccess: begin
        // Decode miss outranks a ready, which outranks the timeout.
        if (!i_reg_hit) begin
          done        = 1'b1;
          done_status = StatusDecodeError;
        end else if (i_reg_ready) begin
          done        = 1'b1;
          done_status = i_reg_status;
          if ((access_q == AccessRead) && !i_reg_status[1]) begin
            done_data = i_reg_read_data;
          end
        end else if ((TIMEOUT_CYCLES > 0) && (count_q == CountLast)) begin
          done        = 1'b1;
          done_status = StatusSlaveError;
        end else if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end

        if (done) begin
          if (access_q == AccessPostedWrite) begin
            posted_error_d = done_status[1];
            state_d        = StIdle;
          end else begin
            status_d    = done_status;
            read_data_d = done_data;
            state_d     = StResponse;
          end
        end
      end

      StResponse: begin
        if (i_host_response_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StIdle;
      access_q       <= 2'b00;
      address_q      <= '0;
      write_data_q   <= '0;
      strobe_q       <= '0;
      status_q       <= 2'b00;
      read_data_q    <= '0;
      count_q        <= '0;
      posted_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      access_q       <= access_d;
      address_q      <= address_d;
      write_data_q   <= write_data_d;
      strobe_q       <= strobe_d;
      status_q       <= status_d;
      read_data_q    <= read_data_d;
      count_q        <= count_d;
      posted_error_q <= posted_error_d;
    end
  end

  assign o_host_ready          = (state_q == StIdle);
  assign o_reg_valid           = (state_q == StAccess);
  assign o_host_response_valid = (state_q == StResponse);
  assign o_host_status         = status_q;
  assign o_host_read_data      = read_data_q;
  assign o_posted_error        = posted_error_q;
  assign o_reg_access          = access_q;
  assign o_reg_address         = address_q;
  assign o_reg_write_data      = write_data_q;
  assign o_reg_strobe          = strobe_q;

endmodule

// File: tb/tb_rggen_register_access_sequencer.sv
// Randomized self-checking bench for the register access sequencer against a
// per-transaction outcome model.
module tb_rggen_register_access_sequencer;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int T  = 15;

  logic          clk;
  logic          rst;
  logic          host_valid;
  logic          host_ready;
  logic [1:0]    host_access;
  logic [AW-1:0] host_address;
  logic [DW-1:0] host_write_data;
  logic [DW-1:0] host_strobe;
  logic          host_response_valid;
  logic          host_response_ready;
  logic [1:0]    host_status;
  logic [DW-1:0] host_read_data;
  logic          posted_error;
  logic          reg_valid;
  logic [1:0]    reg_access;
  logic [AW-1:0] reg_address;
  logic [DW-1:0] reg_write_data;
  logic [DW-1:0] reg_strobe;
  logic          reg_hit;
  logic          reg_ready;
  logic [1:0]    reg_status;
  logic [DW-1:0] reg_read_data;

  int checks = 0;
  int errors = 0;

  rggen_register_access_sequencer #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_host_valid         (host_valid),
    .o_host_ready         (host_ready),
    .i_host_access        (host_access),
    .i_host_address       (host_address),
    .i_host_write_data    (host_write_data),
    .i_host_strobe        (host_strobe),
    .o_host_response_valid(host_response_valid),
    .i_host_response_ready(host_response_ready),
    .o_host_status        (host_status),
    .o_host_read_data     (host_read_data),
    .o_posted_error       (posted_error),
    .o_reg_valid          (reg_valid),
    .o_reg_access         (reg_access),
    .o_reg_address        (reg_address),
    .o_reg_write_data     (reg_write_data),
    .o_reg_strobe         (reg_strobe),
    .i_reg_hit            (reg_hit),
    .i_reg_ready          (reg_ready),
    .i_reg_status         (reg_status),
    .i_reg_read_data      (reg_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outcome of one transaction from the request and the register-side behaviour.
  // rc is the ACCESS cycle (1-based) in which the register raises ready; 0 means never.
  function automatic void model(input logic [1:0] acc, input bit hit, input int rc,
                                input logic [1:0] st, input logic [31:0] rd,
                                output int cycles, output logic [1:0] es,
                                output logic [31:0] ed, output bit resp, output bit perr);
    ed = 32'h0;
    if (acc == 2'b00) begin
      cycles = 0;
      es     = 2'b10;
    end else if (!hit) begin
      cycles = 1;
      es     = 2'b11;
    end else if (rc >= 1 && rc <= T) begin
      cycles = rc;
      es     = st;
      if (acc == 2'b10 && (st == 2'b00 || st == 2'b01)) ed = rd;
    end else begin
      cycles = T;
      es     = 2'b10;
    end
    resp = (acc != 2'b01);
    perr = !resp && (es == 2'b10 || es == 2'b11);
  endfunction

  task automatic run_txn(input logic [1:0] acc, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] strb,
                         input bit hit, input int rc, input logic [1:0] st,
                         input logic [DW-1:0] rd, input int hold);
    int         cycles;
    logic [1:0] es;
    logic [31:0] ed;
    bit         resp;
    bit         perr;
    int         n;
    model(acc, hit, rc, st, rd, cycles, es, ed, resp, perr);

    @(negedge clk);
    check_eq("idle_ready", host_ready, 1);
    host_valid      = 1'b1;
    host_access     = acc;
    host_address    = addr;
    host_write_data = wdata;
    host_strobe     = strb;
    @(posedge clk);
    #1;
    host_valid = 1'b0;

    n = 0;
    while (reg_valid && n < 40) begin
      n++;
      check_eq("reg_access", reg_access, acc);
      check_eq("reg_address", reg_address, addr);
      check_eq("reg_write_data", reg_write_data, wdata);
      check_eq("reg_strobe", reg_strobe, strb);
      check_eq("busy_ready", host_ready, 0);
      reg_hit       = hit;
      reg_ready     = (n == rc);
      reg_status    = st;
      reg_read_data = (n == rc) ? rd : $urandom;
      // Requests offered while busy must be ignored.
      host_valid    = 1'($urandom_range(0, 1));
      host_access   = 2'($urandom);
      host_address  = AW'($urandom);
      @(posedge clk);
      #1;
      host_valid = 1'b0;
      reg_ready  = 1'b0;
      reg_hit    = 1'b1;
    end
    check_eq("reg_valid_cycles", n, cycles);

    if (resp) begin
      for (int i = 0; i <= hold; i++) begin
        check_eq("resp_valid", host_response_valid, 1);
        check_eq("resp_status", host_status, es);
        check_eq("resp_data", host_read_data, ed);
        check_eq("resp_host_ready", host_ready, 0);
        check_eq("resp_reg_valid", reg_valid, 0);
        host_response_ready = (i == hold);
        @(posedge clk);
        #1;
        host_response_ready = 1'b0;
      end
      check_eq("after_resp_valid", host_response_valid, 0);
      check_eq("after_resp_ready", host_ready, 1);
      check_eq("after_resp_perr", posted_error, 0);
    end else begin
      check_eq("posted_no_resp", host_response_valid, 0);
      check_eq("posted_error", posted_error, perr);
      check_eq("posted_ready", host_ready, 1);
      @(posedge clk);
      #1;
      check_eq("posted_error_clear", posted_error, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_host_ready"}, host_ready, 1);
    check_eq({tag, "_resp_valid"}, host_response_valid, 0);
    check_eq({tag, "_status"}, host_status, 0);
    check_eq({tag, "_read_data"}, host_read_data, 0);
    check_eq({tag, "_perr"}, posted_error, 0);
    check_eq({tag, "_reg_valid"}, reg_valid, 0);
    check_eq({tag, "_reg_access"}, reg_access, 0);
    check_eq({tag, "_reg_address"}, reg_address, 0);
    check_eq({tag, "_reg_wdata"}, reg_write_data, 0);
    check_eq({tag, "_reg_strobe"}, reg_strobe, 0);
  endtask

  initial begin
    rst                 = 1'b1;
    host_valid          = 1'b0;
    host_access         = 2'b00;
    host_address        = '0;
    host_write_data     = '0;
    host_strobe         = '0;
    host_response_ready = 1'b0;
    reg_hit             = 1'b1;
    reg_ready           = 1'b0;
    reg_status          = 2'b00;
    reg_read_data       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    run_txn(2'b10, 8'h10, 32'h0, 32'h0, 1, 1, 2'b00, 32'hDEADBEEF, 3);
    run_txn(2'b11, 8'hFC, 32'h1234, 32'hFFFF, 0, 0, 2'b00, 32'h0, 0);
    run_txn(2'b10, 8'h20, 32'h0, 32'h0, 1, 0, 2'b00, 32'h0, 1);
    run_txn(2'b10, 8'h24, 32'h0, 32'h0, 1, 15, 2'b00, 32'hCAFE0015, 0);
    run_txn(2'b01, 8'h30, 32'h55, 32'hFF, 1, 1, 2'b10, 32'h0, 0);
    run_txn(2'b01, 8'h30, 32'h55, 32'hFF, 1, 1, 2'b00, 32'h0, 0);
    run_txn(2'b00, 8'h40, 32'h0, 32'h0, 1, 1, 2'b00, 32'h0, 0);
    run_txn(2'b10, 8'h44, 32'h0, 32'h0, 0, 1, 2'b00, 32'hBAD0BAD0, 0);
    run_txn(2'b10, 8'h48, 32'h0, 32'h0, 1, 2, 2'b01, 32'h0BADF00D, 0);
    run_txn(2'b10, 8'h4C, 32'h0, 32'h0, 1, 3, 2'b10, 32'h11111111, 0);

    // Reset in the middle of an access.
    @(negedge clk);
    host_valid   = 1'b1;
    host_access  = 2'b10;
    host_address = 8'h5A;
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    reg_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_reset_reg_valid", reg_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    check_eq("midreset_no_resp", host_response_valid, 0);
    check_eq("midreset_no_perr", posted_error, 0);
    run_txn(2'b10, 8'h10, 32'h0, 32'h0, 1, 1, 2'b00, 32'h600DDA7A, 0);

    for (int k = 0; k < 60; k++) begin
      run_txn(2'($urandom_range(0, 3)), AW'($urandom), $urandom, $urandom,
              $urandom_range(0, 4) != 0, $urandom_range(0, 17), 2'($urandom),
              $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
